lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit between the pipelined datapath's Memory stage and a handshaked data-memory bus.
- Takes the M-stage address, store data, funct3 and read/write strobes; issues one valid/ready bus transaction per access.
- Stalls the pipeline until the transaction completes, then returns aligned, sign- or zero-extended load data for the MW pipeline register.
- Generates byte enables and lane-replicated store data for SB/SH/SW.

Parameters:
TIMEOUT, 255, max cycles waiting for bus_ready before the access is aborted (1..65535)
CNT_W, 16, width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
MemReadM  in  1  M-stage load strobe
MemWriteM  in  1  M-stage store strobe
funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
AddrM  in  32  byte address (ALUResultM)
WriteDataM  in  32  store data, low bits significant
ReadDataM  out  32  aligned/extended load result, valid in DONE
StallMem  out  1  hold F/D/E/M stages while high
bus_valid  out  1  request valid
bus_we  out  1  1 = write
bus_addr  out  32  word address {AddrM[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_ready  in  1  slave accepts/completes request this cycle
bus_rdata  in  32  read word, valid when bus_valid & bus_ready
BusErr  out  1  one-cycle pulse on timeout abort
MisalignErr  out  1  one-cycle pulse on misaligned access (see Optional Feature)

Behaviour:
- Reset (async, reset=0): state IDLE, counter 0, all outputs 0; an in-flight bus_valid drops immediately, with no completion or error pulse.
- States: IDLE, REQ, DONE.
- IDLE: access = MemReadM|MemWriteM. If asserted:
  - StallMem=1 combinationally in the same cycle.
  - Latch addr, funct3, we, formatted wdata and be.
  - Next state REQ (or DONE, see feature).
- Write priority: if both strobes are set, a write is performed.
- REQ:
  - bus_valid=1; bus_we/addr/wdata/be come from the latched values and stay stable until handshake.
  - StallMem=1; counter increments each cycle.
  - Handshake (bus_valid & bus_ready): capture bus_rdata, go to DONE.
  - Counter reaching TIMEOUT without ready: drop valid, go to DONE, pulse BusErr in DONE, load data 0.
- DONE:
  - StallMem=0, bus_valid=0; ReadDataM driven from captured data; counter cleared.
  - The M instruction advances at the end of this cycle; next state is always IDLE.
  - ReadDataM holds its value until the next DONE.
- Minimum occupancy with a zero-wait slave is 3 cycles: IDLE-detect, REQ, DONE. Each wait state adds one cycle.
- Store format:
  - SB: be=0001<<AddrM[1:0], wdata={4{byte}}.
  - SH: be = AddrM[1] ? 1100 : 0011, wdata={2{half}}.
  - SW/other: be=1111, wdata=WriteDataM.
- Load extract:
  - B/BU select byte AddrM[1:0]; H/HU select half AddrM[1].
  - B/H sign-extend; BU/HU zero-extend.
  - W and undefined funct3 (011,110,111) return the full word.
- Without the feature:
  - H ignores AddrM[0]; W ignores AddrM[1:0].
  - MisalignErr is tied 0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: H with AddrM[0]=1, or W with AddrM[1:0]!=0, skips REQ and goes IDLE→DONE with no bus transaction. MisalignErr pulses in DONE; load result is 0; no memory write occurs.
- Undefined: no misalignment check; addresses are truncated as described in Behaviour; MisalignErr is constant 0.

Test Plan:
- Zero-wait SW to 0x100, data 0xDEADBEEF, ready=1 → bus_valid 1 cycle, addr 0x100, be 1111, wdata 0xDEADBEEF; StallMem high 2 cycles, low in DONE.
- SB to 0x103, data 0x000000A5 → be 1000, wdata 0xA5A5A5A5; SH to 0x102, data 0x1234 → be 1100, wdata 0x12341234.
- LB/LBU from 0x201, ready after 3 wait cycles, rdata 0x00008000 → LB gives 0xFFFFFF80, LBU gives 0x00000080; StallMem high 5 cycles.
- TIMEOUT=4, ready held 0 → bus_valid drops after 4 REQ cycles; BusErr pulses once; ReadDataM=0; FSM returns to IDLE.
- Reset asserted during REQ → bus_valid and StallMem go 0 asynchronously; after release, a new LW completes normally.
- With MISALIGN_TRAP_EN, LW at 0x302 → no bus_valid, MisalignErr 1-cycle pulse, ReadDataM=0. Without the macro → bus_addr 0x300, be 1111.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: M-stage access -> one valid/ready bus transaction, with stall and load formatting.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of truncating the address.
//
// state | meaning
// IDLE  | waiting for MemReadM/MemWriteM; stall asserted combinationally on detect
// REQ   | bus_valid high, waiting for bus_ready or timeout
// DONE  | access complete, pipeline released, result/error pulses presented
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        BusErr,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nx;
  logic              access;
  logic              misaligned;
  logic              timeout;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       rdata_q;
  logic              bus_err_q;
  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_fmt;

  assign access  = MemReadM | MemWriteM;
  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  assign misaligned = (((funct3M == 3'b001) || (funct3M == 3'b101)) && AddrM[0]) ||
                      ((funct3M == 3'b010) && (AddrM[1:0] != 2'b00));
  assign MisalignErr = mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= (state == IDLE) && access && misaligned;
  end
`else
  assign misaligned  = 1'b0;
  assign MisalignErr = 1'b0;
`endif

  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = WriteDataM;
    case (funct3M)
      3'b000: begin
        fmt_be    = 4'b0001 << AddrM[1:0];
        fmt_wdata = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        fmt_be    = AddrM[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      2'd3:    ld_byte = bus_rdata[31:24];
      default: ld_byte = bus_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = bus_rdata;
    endcase
  end

  always_comb begin
    state_nx  = state;
    StallMem  = 1'b0;
    bus_valid = 1'b0;
    case (state)
      IDLE: begin
        // reset gates the combinational stall so all outputs read 0 while held in reset
        if (access && reset) begin
          StallMem = 1'b1;
          state_nx = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        StallMem  = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready || timeout) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus_we    = bus_valid & we_q;
  assign bus_addr  = bus_valid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_wdata = bus_valid ? wdata_q : 32'd0;
  assign bus_be    = bus_valid ? be_q : 4'd0;
  assign ReadDataM = rdata_q;
  assign BusErr    = bus_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      bus_err_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (access) begin
            addr_q  <= AddrM;
            f3_q    <= funct3M;
            we_q    <= MemWriteM;
            wdata_q <= fmt_wdata;
            be_q    <= fmt_be;
            if (misaligned) rdata_q <= 32'd0;
          end
        end
        REQ: begin
          if (bus_ready) begin
            rdata_q <= ld_fmt;
            cnt     <= '0;
          end else if (timeout) begin
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: expected transactions queued at drive time, popped at DONE.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] AddrM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        BusErr, MisalignErr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    int          stall;
    int          vcnt;
    logic        buserr;
    logic        mis;
    bit          chk_rd;
    bit          chk_be;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallMem(StallMem), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .BusErr(BusErr), .MisalignErr(MisalignErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                              input logic we, input logic [31:0] rdata, input int stall, input int vcnt,
                              input logic buserr, input logic mis, input bit chk_rd, input bit chk_be);
    exp_t e;
    e.addr = addr; e.be = be; e.wdata = wdata; e.we = we; e.rdata = rdata;
    e.stall = stall; e.vcnt = vcnt; e.buserr = buserr; e.mis = mis;
    e.chk_rd = chk_rd; e.chk_be = chk_be;
    return e;
  endfunction

  // Drives one access, plays a slave that raises ready after `waits` valid cycles, checks at DONE.
  task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input logic [31:0] rword, input exp_t e);
    int          stall, vcnt;
    bit          done;
    logic [31:0] f_addr, f_wdata;
    logic [3:0]  f_be;
    logic        f_we;
    exp_t        x;
    stall = 0; vcnt = 0; done = 1'b0;
    f_addr = 32'd0; f_wdata = 32'd0; f_be = 4'd0; f_we = 1'b0;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; AddrM = a; WriteDataM = wd;
    bus_ready = 1'b0; bus_rdata = rword;
    sb.push_back(e);
    #1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (!StallMem) begin
        done = 1'b1;
      end else begin
        stall++;
        if (bus_valid) begin
          vcnt++;
          if (vcnt == 1) begin
            f_addr = bus_addr; f_wdata = bus_wdata; f_be = bus_be; f_we = bus_we;
          end
          bus_ready = (vcnt > waits);
        end else begin
          bus_ready = 1'b0;
        end
        @(negedge clk); #1;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    x = sb.pop_front();
    chk({tag, "_stall"}, 32'(stall), 32'(x.stall));
    chk({tag, "_vcnt"}, 32'(vcnt), 32'(x.vcnt));
    chk({tag, "_valid_done"}, 32'(bus_valid), 32'd0);
    if (x.vcnt > 0) begin
      chk({tag, "_addr"}, f_addr, x.addr);
      chk({tag, "_we"}, 32'(f_we), 32'(x.we));
      if (x.chk_be) chk({tag, "_be"}, 32'(f_be), 32'(x.be));
      if (x.we) chk({tag, "_wdata"}, f_wdata, x.wdata);
    end
    if (x.chk_rd) chk({tag, "_rdata"}, ReadDataM, x.rdata);
    chk({tag, "_buserr"}, 32'(BusErr), 32'(x.buserr));
    chk({tag, "_mis"}, 32'(MisalignErr), 32'(x.mis));
    MemReadM = 1'b0; MemWriteM = 1'b0; bus_ready = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_buserr_clr"}, 32'(BusErr), 32'd0);
    chk({tag, "_mis_clr"}, 32'(MisalignErr), 32'd0);
    chk({tag, "_idle_stall"}, 32'(StallMem), 32'd0);
    if (x.chk_rd) chk({tag, "_rdata_hold"}, ReadDataM, x.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0;
    AddrM = 32'd0; WriteDataM = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
    #1;
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_stall", 32'(StallMem), 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_buserr", 32'(BusErr), 32'd0);
    chk("rst_mis", 32'(MisalignErr), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    access("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0,
           mk(32'h100, 4'b1111, 32'hDEADBEEF, 1, 0, 2, 1, 0, 0, 0, 1));
    access("sb", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0,
           mk(32'h100, 4'b1000, 32'hA5A5A5A5, 1, 0, 2, 1, 0, 0, 0, 1));
    access("sh", 0, 1, 3'b001, 32'h102, 32'h00001234, 0, 32'h0,
           mk(32'h100, 4'b1100, 32'h12341234, 1, 0, 2, 1, 0, 0, 0, 1));
    access("lb", 1, 0, 3'b000, 32'h201, 32'h0, 3, 32'h00008000,
           mk(32'h200, 4'b0000, 32'h0, 0, 32'hFFFFFF80, 5, 4, 0, 0, 1, 0));
    access("lbu", 1, 0, 3'b100, 32'h201, 32'h0, 3, 32'h00008000,
           mk(32'h200, 4'b0000, 32'h0, 0, 32'h00000080, 5, 4, 0, 0, 1, 0));
    access("lh", 1, 0, 3'b001, 32'h202, 32'h0, 1, 32'h80010000,
           mk(32'h200, 4'b0000, 32'h0, 0, 32'hFFFF8001, 3, 2, 0, 0, 1, 0));
    access("lhu", 1, 0, 3'b101, 32'h202, 32'h0, 0, 32'h80010000,
           mk(32'h200, 4'b0000, 32'h0, 0, 32'h00008001, 2, 1, 0, 0, 1, 0));
    access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 2, 32'h13579BDF,
           mk(32'h100, 4'b0000, 32'h0, 0, 32'h13579BDF, 4, 3, 0, 0, 1, 0));
    access("tmo", 1, 0, 3'b010, 32'h104, 32'h0, 100, 32'hFFFFFFFF,
           mk(32'h104, 4'b0000, 32'h0, 0, 32'h0, 5, 4, 1, 0, 1, 0));
    access("both", 1, 1, 3'b010, 32'h108, 32'h0BADF00D, 0, 32'h0,
           mk(32'h108, 4'b1111, 32'h0BADF00D, 1, 0, 2, 1, 0, 0, 0, 1));
    access("lundef", 1, 0, 3'b011, 32'h10C, 32'h0, 0, 32'hCAFEF00D,
           mk(32'h10C, 4'b0000, 32'h0, 0, 32'hCAFEF00D, 2, 1, 0, 0, 1, 0));
`ifdef MISALIGN_TRAP_EN
    access("lw_mis", 1, 0, 3'b010, 32'h302, 32'h0, 0, 32'h11223344,
           mk(32'h0, 4'b0000, 32'h0, 0, 32'h0, 1, 0, 0, 1, 1, 0));
    access("lh_mis", 1, 0, 3'b001, 32'h203, 32'h0, 0, 32'h80010000,
           mk(32'h0, 4'b0000, 32'h0, 0, 32'h0, 1, 0, 0, 1, 1, 0));
    access("sw_mis", 0, 1, 3'b010, 32'h301, 32'h55555555, 0, 32'h0,
           mk(32'h0, 4'b0000, 32'h0, 0, 32'h0, 1, 0, 0, 1, 0, 0));
`else
    access("lw_mis", 1, 0, 3'b010, 32'h302, 32'h0, 0, 32'h11223344,
           mk(32'h300, 4'b1111, 32'h0, 0, 32'h11223344, 2, 1, 0, 0, 1, 1));
    access("lh_mis", 1, 0, 3'b001, 32'h203, 32'h0, 0, 32'h80010000,
           mk(32'h200, 4'b0000, 32'h0, 0, 32'hFFFF8001, 2, 1, 0, 0, 1, 0));
`endif

    // reset asserted mid-REQ with the load strobe still high
    @(negedge clk);
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; AddrM = 32'h400;
    bus_ready = 1'b0;
    @(negedge clk); #1;
    chk("rstreq_valid_before", 32'(bus_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstreq_valid", 32'(bus_valid), 32'd0);
    chk("rstreq_stall", 32'(StallMem), 32'd0);
    chk("rstreq_buserr", 32'(BusErr), 32'd0);
    chk("rstreq_rdata", ReadDataM, 32'd0);
    MemReadM = 1'b0;
    @(negedge clk); #1;
    chk("rstreq_held_valid", 32'(bus_valid), 32'd0);
    reset = 1'b1;
    access("lw_after_rst", 1, 0, 3'b010, 32'h404, 32'h0, 0, 32'h5A5A1234,
           mk(32'h404, 4'b0000, 32'h0, 0, 32'h5A5A1234, 2, 1, 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
